// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front-end upstream of the IF/ID register.
// Owns the fetch PC, issues in-order requests to instruction memory, buffers
// the returned instructions in a small FIFO and presents {inst, pc+4} to IF/ID.
// A taken-branch redirect flushes the FIFO and drops every response still in
// flight. Reset is synchronous and active-low.
//
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to the
// outputs when the FIFO is empty, saving one cycle of latency.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order fetch responses
//   stall                           hold the head (hazard unit)
//   redirect, redirect_pc           flush and refetch from redirect_pc
//   inst_valid, inst, inst_pc_plus4 head instruction to IF/ID
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc_plus4
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    // In-flight/discard counters are sized for the memory pipeline, not DEPTH:
    // repeated redirects can stack stale requests beyond DEPTH.
    localparam int unsigned FlyW = 8;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [FlyW-1:0] inflight_q, inflight_d;
    logic [FlyW-1:0] discard_q, discard_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]     fifo_q [DEPTH];

    logic [FlyW:0]   occupancy;
    logic [63:0]     head;
    logic            req_fire;
    logic            rsp_useful;
    logic            bypass;
    logic            bypass_take;
    logic            push;
    logic            pop;

    always_comb begin
        head = fifo_q[rd_ptr_q];
        // Buffered entries plus useful (non-discarded) requests in flight.
        occupancy = {{(FlyW + 1 - CntW){1'b0}}, count_q} + {1'b0, inflight_q - discard_q};

        imem_req_valid = reset && !redirect && (occupancy < (FlyW + 1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_useful = imem_rsp_valid && (discard_q == '0) && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass = rsp_useful && (count_q == '0);
`else
        bypass = 1'b0;
`endif
        bypass_take = bypass && !stall;
        push        = rsp_useful && !bypass_take;
        pop         = (count_q != '0) && !stall && !redirect;

        inst_valid    = (count_q != '0) || bypass;
        inst          = 32'h0;
        inst_pc_plus4 = 32'h0;
        if (bypass) begin
            inst          = imem_rsp_data;
            inst_pc_plus4 = rsp_pc_q + 32'd4;
        end else if (count_q != '0) begin
            inst          = head[31:0];
            inst_pc_plus4 = head[63:32];
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rsp_pc_d   = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // No request can fire in a redirect cycle; this cycle's response
            // retires here and everything still outstanding becomes stale.
            inflight_d = inflight_q - FlyW'(imem_rsp_valid);
            discard_d  = inflight_q - FlyW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            inflight_d = inflight_q + FlyW'(req_fire) - FlyW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - FlyW'(1);
            end
            if (rsp_useful) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {rsp_pc_q + 32'd4, imem_rsp_data};
        end
    end

    // The credit scheme keeps a full FIFO from ever seeing another response.
    assert property (@(posedge clk) disable iff (!reset)
                     !(imem_rsp_valid && (count_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYPASS    = 1'b1;
    localparam int FIRST_CYC = 2;
`else
    localparam bit BYPASS    = 1'b0;
    localparam int FIRST_CYC = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc_plus4;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    // Accepted request awaiting its response: address actually issued, PC the
    // reference expects it to be, earliest response cycle, killed by redirect.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] fifo_m[$];   // PCs of buffered instructions, head first
    logic [31:0] pc_m;
    int          cyc;
    int          lat;
    int unsigned ready_pct, stall_pct, hold_pct, redir_pct;
    int          errors = 0;
    int          checks = 0;

    logic        exp_valid, exp_req_valid;
    logic [31:0] exp_inst, exp_pc4, exp_req_addr;
    bit          byp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Drive one cycle's inputs (just after posedge) and derive expectations.
    task automatic step_begin(input bit redir, input logic [31:0] tgt);
        int useful;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        stall          = ($urandom_range(99) < stall_pct);
        redirect       = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) >= hold_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end
        useful = 0;
        foreach (mq[i]) if (!mq[i].stale) useful++;
        exp_req_valid = !redir && ((fifo_m.size() + useful) < DEPTH);
        exp_req_addr  = pc_m;
        byp = BYPASS && imem_rsp_valid && !mq[0].stale && !redir && (fifo_m.size() == 0);
        exp_valid = 1'b0;
        exp_inst  = 32'h0;
        exp_pc4   = 32'h0;
        if (fifo_m.size() > 0) begin
            exp_valid = 1'b1;
            exp_inst  = mem_word(fifo_m[0]);
            exp_pc4   = fifo_m[0] + 32'd4;
        end else if (byp) begin
            exp_valid = 1'b1;
            exp_inst  = mem_word(mq[0].exp_pc);
            exp_pc4   = mq[0].exp_pc + 32'd4;
        end
    endtask

    // Advance reference and memory across the coming edge.
    task automatic step_end();
        req_t r;
        bit   had_rsp;
        had_rsp = imem_rsp_valid;
        if (had_rsp) r = mq.pop_front();
        if (redirect) begin
            fifo_m.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            pc_m = {redirect_pc[31:2], 2'b00};
        end else begin
            if (fifo_m.size() > 0 && !stall) void'(fifo_m.pop_front());
            if (had_rsp && !r.stale && !(byp && !stall)) fifo_m.push_back(r.exp_pc);
        end
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, exp_pc: pc_m, due: cyc + lat, stale: 1'b0});
            pc_m = pc_m + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        fifo_m.delete();
        pc_m = RESET_PC;
        cyc  = 1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
            end
            checks++;
            if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc_plus4 !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%b inst=%h pc4=%h want 0/0/0",
                         inst_valid, inst, inst_pc_plus4);
            end
            checks++;
            if (imem_req_addr !== RESET_PC) begin
                errors++;
                $display("FAIL reset_addr: got %h want %h", imem_req_addr, RESET_PC);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_fetch();
        int          first;
        int          na;
        logic [31:0] addrs[3];
        do_reset();
        lat = 1; ready_pct = 100; stall_pct = 0; hold_pct = 0;
        first = 0;
        na    = 0;
        for (int i = 0; i < 12; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            if (imem_req_valid === 1'b1 && na < 3) begin
                addrs[na] = imem_req_addr;
                na++;
            end
            if (first != 0) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc_plus4 !== exp_pc4 || inst !== exp_inst) begin
                    errors++;
                    $display("FAIL stream: got v=%b pc4=%h inst=%h want 1/%h/%h",
                             inst_valid, inst_pc_plus4, inst, exp_pc4, exp_inst);
                end
            end else if (inst_valid === 1'b1) begin
                first = cyc;
                checks++;
                if (inst_pc_plus4 !== 32'h4 || inst !== mem_word(32'h0)) begin
                    errors++;
                    $display("FAIL first_inst: got pc4=%h inst=%h want 00000004/%h",
                             inst_pc_plus4, inst, mem_word(32'h0));
                end
            end
            step_end();
        end
        checks++;
        if (first != FIRST_CYC) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d want %0d", first, FIRST_CYC);
        end
        checks++;
        if (na != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            errors++;
            $display("FAIL req_addr_seq: got n=%0d %h %h %h want 3 0 4 8",
                     na, addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1; ready_pct = 100; stall_pct = 100; hold_pct = 0;
        for (int i = 0; i < 10; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            checks++;
            if (imem_req_valid !== exp_req_valid) begin
                errors++;
                $display("FAIL stall_req_valid: cyc %0d got %b want %b",
                         cyc, imem_req_valid, exp_req_valid);
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (inst_pc_plus4 !== 32'h4) begin
                    errors++;
                    $display("FAIL stall_head: got %h want 00000004", inst_pc_plus4);
                end
            end
            if (i == 9) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_credit: got req_valid %b want 0", imem_req_valid);
                end
            end
            step_end();
        end
        stall_pct = 0;
        for (int i = 0; i < 4; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h4 + 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_release_order: got v=%b pc4=%h want 1/%h",
                         inst_valid, inst_pc_plus4, 32'h4 + 32'(4 * i));
            end
            step_end();
        end
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset();
        lat = 3; ready_pct = 100; stall_pct = 0; hold_pct = 0;
        for (int i = 0; i < 2; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            step_end();
        end
        step_begin(1'b1, 32'h100);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_req: got %b want 0", imem_req_valid);
        end
        step_end();
        step_begin(1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_addr: got v=%b addr=%h want 1/00000100",
                     imem_req_valid, imem_req_addr);
        end
        step_end();
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (inst_pc_plus4 !== 32'h104 || inst !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL redir_first: got pc4=%h inst=%h want 00000104/%h",
                             inst_pc_plus4, inst, mem_word(32'h100));
                end
            end
            step_end();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL redir_timeout: got no inst_valid want one within 12 cycles");
        end
    endtask

    task automatic test_redirect_same_rsp();
        int          n;
        logic [31:0] got[2];
        do_reset();
        lat = 2; ready_pct = 100; stall_pct = 0; hold_pct = 0;
        for (int i = 0; i < 5; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            step_end();
        end
        step_begin(1'b1, 32'h200);
        @(negedge clk);
        step_end();
        n = 0;
        for (int i = 0; i < 12 && n < 2; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_rsp_flush: got inst_valid %b want 0", inst_valid);
                end
            end
            if (inst_valid === 1'b1) begin
                got[n] = inst_pc_plus4;
                checks++;
                if (inst !== mem_word(inst_pc_plus4 - 32'd4)) begin
                    errors++;
                    $display("FAIL redir_rsp_data: got %h want %h",
                             inst, mem_word(inst_pc_plus4 - 32'd4));
                end
                n++;
            end
            step_end();
        end
        checks++;
        if (n != 2 || got[0] !== 32'h204 || got[1] !== 32'h208) begin
            errors++;
            $display("FAIL redir_rsp_order: got n=%0d %h %h want 2 00000204 00000208",
                     n, got[0], got[1]);
        end
    endtask

    task automatic test_wrap();
        bit seen;
        do_reset();
        lat = 1; ready_pct = 100; stall_pct = 0; hold_pct = 0;
        step_begin(1'b1, 32'hFFFF_FFFE);
        @(negedge clk);
        step_end();
        step_begin(1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0: got %h want fffffffc", imem_req_addr);
        end
        step_end();
        step_begin(1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1: got %h want 00000000", imem_req_addr);
        end
        step_end();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step_begin(1'b0, 32'h0);
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (inst_pc_plus4 !== 32'h0 || inst !== mem_word(32'hFFFF_FFFC)) begin
                    errors++;
                    $display("FAIL wrap_pc4: got pc4=%h inst=%h want 00000000/%h",
                             inst_pc_plus4, inst, mem_word(32'hFFFF_FFFC));
                end
            end
            step_end();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wrap_timeout: got no inst_valid want one within 6 cycles");
        end
    endtask

    task automatic test_random();
        for (int l = 1; l <= 3; l++) begin
            do_reset();
            lat = l; ready_pct = 50; stall_pct = 30; hold_pct = 20; redir_pct = 4;
            for (int i = 0; i < 300; i++) begin
                step_begin($urandom_range(99) < redir_pct, $urandom);
                @(negedge clk);
                checks++;
                if (imem_req_valid !== exp_req_valid) begin
                    errors++;
                    $display("FAIL rnd_req_valid: lat %0d cyc %0d got %b want %b",
                             l, cyc, imem_req_valid, exp_req_valid);
                end
                if (exp_req_valid) begin
                    checks++;
                    if (imem_req_addr !== exp_req_addr) begin
                        errors++;
                        $display("FAIL rnd_req_addr: lat %0d cyc %0d got %h want %h",
                                 l, cyc, imem_req_addr, exp_req_addr);
                    end
                end
                checks++;
                if (inst_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL rnd_inst_valid: lat %0d cyc %0d got %b want %b",
                             l, cyc, inst_valid, exp_valid);
                end else if (exp_valid) begin
                    checks++;
                    if (inst !== exp_inst || inst_pc_plus4 !== exp_pc4) begin
                        errors++;
                        $display("FAIL rnd_inst: lat %0d cyc %0d got %h/%h want %h/%h",
                                 l, cyc, inst, inst_pc_plus4, exp_inst, exp_pc4);
                    end
                end
                step_end();
            end
        end
    endtask

    initial begin
        lat = 1; ready_pct = 100; stall_pct = 0; hold_pct = 0; redir_pct = 0;
        cyc = 0;
        pc_m = RESET_PC;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_redirect_same_rsp();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "simulation timeout");
    end

endmodule
